// File: rtl/stage5_field_dict.sv
// stage5_field_dict: copy-operator field dictionary plus one-slot registered message pipeline
module stage5_field_dict #(
  parameter int MSG_W = 512,
  parameter int FLD_W = 8,
  parameter logic [FLD_W-1:0] PID_INIT = 8'h00,
  parameter logic [FLD_W-1:0] MC_INIT = 8'h00,
  parameter logic [FLD_W-1:0] MT_INIT = 8'h00,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       msg_vld,
  input  logic [MSG_W-1:0] message_1,
  input  logic [MSG_W-1:0] message_2,
  input  logic [MSG_W-1:0] message_3,
  input  logic             dict_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_msg_vld,
  output logic [MSG_W-1:0] out_message_1,
  output logic [MSG_W-1:0] out_message_2,
  output logic [MSG_W-1:0] out_message_3,
  output logic [FLD_W-1:0] field_PID1,
  output logic [FLD_W-1:0] field_MC1,
  output logic [FLD_W-1:0] field_MT1,
  output logic [CNT_W-1:0] msg_cnt
);
  logic             valid_q, valid_d, accept, upd;
  logic [2:0]       vld_q, vld_d;
  logic [MSG_W-1:0] m1_q, m1_d, m2_q, m2_d, m3_q, m3_d, sel;
  logic [FLD_W-1:0] pid_q, pid_d, mc_q, mc_d, mt_q, mt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign in_ready = !valid_q || out_ready;
  assign accept = in_valid && in_ready;
  assign upd = accept && |msg_vld;
  // Next state: slot loads on accept; dictionary follows the newest valid message, a same-edge clear only wins when no update
  always_comb begin
    sel = msg_vld[2] ? message_3 : msg_vld[1] ? message_2 : message_1;
    valid_d = accept || (valid_q && !out_ready);
    vld_d = accept ? msg_vld : vld_q;
    m1_d = accept ? message_1 : m1_q;
    m2_d = accept ? message_2 : m2_q;
    m3_d = accept ? message_3 : m3_q;
    pid_d = upd ? sel[MSG_W-1 -: FLD_W] : dict_clear ? PID_INIT : pid_q;
    mc_d = upd ? sel[MSG_W-1-FLD_W -: FLD_W] : dict_clear ? MC_INIT : mc_q;
    mt_d = upd ? sel[MSG_W-1-2*FLD_W -: FLD_W] : dict_clear ? MT_INIT : mt_q;
    cnt_d = accept ? cnt_q + CNT_W'(msg_vld[0]) + CNT_W'(msg_vld[1]) + CNT_W'(msg_vld[2]) : cnt_q;
  end
  // State registers; reset discards any held beat
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      vld_q <= '0;
      m1_q <= '0;
      m2_q <= '0;
      m3_q <= '0;
      pid_q <= PID_INIT;
      mc_q <= MC_INIT;
      mt_q <= MT_INIT;
      cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      vld_q <= vld_d;
      m1_q <= m1_d;
      m2_q <= m2_d;
      m3_q <= m3_d;
      pid_q <= pid_d;
      mc_q <= mc_d;
      mt_q <= mt_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = valid_q;
  assign out_msg_vld = vld_q;
  assign out_message_1 = m1_q;
  assign out_message_2 = m2_q;
  assign out_message_3 = m3_q;
  assign field_PID1 = pid_q;
  assign field_MC1 = mc_q;
  assign field_MT1 = mt_q;
  assign msg_cnt = cnt_q;
endmodule
